// File: rtl/dram_arbiter_rr.sv
// Single-port DRAM arbiter for a multi-core array: serves one core request at a
// time (round-robin or fixed priority) and aggregates the per-core done flags.
module dram_arbiter_rr #(
    parameter int WIDTH     = 8,
    parameter int NUM_CORES = 4,
    parameter int READ_LAT  = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                           Clk,
    input  logic                           RST,
    input  logic [NUM_CORES-1:0]           core_rd,
    input  logic [NUM_CORES-1:0]           core_wr,
    input  logic [NUM_CORES*WIDTH-1:0]     core_addr,
    input  logic [NUM_CORES*WIDTH-1:0]     core_wdata,
    input  logic [NUM_CORES-1:0]           core_done,
    output logic [NUM_CORES-1:0]           core_memAV,
    output logic [WIDTH-1:0]               core_rdata,
    output logic [WIDTH-1:0]               dram_addr,
    output logic [WIDTH-1:0]               dram_wdata,
    output logic                           dram_we,
    output logic                           dram_re,
    input  logic [WIDTH-1:0]               dram_rdata,
    output logic [$clog2(NUM_CORES)-1:0]   grant_id,
    output logic                           busy,
    output logic                           all_done,
    output logic [1:0]                     o_dbg_state
);

    localparam int GW = $clog2(NUM_CORES);
    localparam int CW = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Handshake: a core raises core_rd/core_wr (with addr/wdata stable) and holds
    // it; the arbiter answers with a one-cycle core_memAV pulse once the access is done.
    state_t               r_state;
    state_t               w_next;
    logic [NUM_CORES-1:0] w_req;
    logic [GW-1:0]        w_base;
    logic [GW:0]          w_sum;
    logic [GW-1:0]        w_idx;
    logic [GW-1:0]        w_winner;
    logic                 w_found;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last_grant;
    logic                 r_is_wr;
    logic [WIDTH-1:0]     r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_rdata;
    logic [CW-1:0]        r_cnt;
    logic                 r_all_done;

    assign w_req = core_rd | core_wr;

    // Search starts one past the last winner in round-robin mode, at core 0 otherwise.
    always_comb begin
        w_base   = '0;
        w_sum    = '0;
        w_idx    = '0;
        w_winner = '0;
        w_found  = 1'b0;
        if (PRIO_MODE == 0 && r_last_grant != GW'(NUM_CORES - 1)) begin
            w_base = r_last_grant + GW'(1);
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            w_sum = {1'b0, w_base} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NUM_CORES)) begin
                w_sum = w_sum - (GW+1)'(NUM_CORES);
            end
            w_idx = w_sum[GW-1:0];
            if (!w_found && w_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = r_is_wr ? S_ACK : S_WAIT;
            S_WAIT:  if (r_cnt == CW'(1)) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_CORES - 1);
            r_is_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_all_done   <= 1'b0;
        end else begin
            r_all_done <= &core_done;
            case (r_state)
                S_IDLE: begin
                    // A simultaneous read+write from one core is served as the write.
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_is_wr <= core_wr[w_winner];
                        r_addr  <= core_addr[w_winner*WIDTH +: WIDTH];
                        r_wdata <= core_wdata[w_winner*WIDTH +: WIDTH];
                    end
                end
                S_ISSUE: begin
                    if (!r_is_wr) r_cnt <= CW'(READ_LAT);
                end
                S_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        r_rdata <= dram_rdata;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        core_memAV = '0;
        if (r_state == S_ACK) core_memAV[r_grant] = 1'b1;
    end

    assign dram_we     = (r_state == S_ISSUE) && r_is_wr;
    assign dram_re     = (r_state == S_ISSUE) && !r_is_wr;
    assign dram_addr   = r_addr;
    assign dram_wdata  = r_wdata;
    assign core_rdata  = r_rdata;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign all_done    = r_all_done;
    assign o_dbg_state = r_state;

endmodule
